// File: rtl/gb_mbc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_mbc_pkg
// Description : Shared types and constants for the Game Boy MBC front end.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_mbc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_LOW  = 2'd1,
        ST_WR_DONE = 2'd2,
        ST_ABORT   = 2'd3
    } gb_cap_state_t;

    localparam logic [1:0] REG_RAM_EN   = 2'd0;
    localparam logic [1:0] REG_ROM_BANK = 2'd1;
    localparam logic [1:0] REG_RAM_BANK = 2'd2;
    localparam logic [1:0] REG_MODE     = 2'd3;

    // {A15,A14,A13} of the external cartridge RAM window A000-BFFF
    localparam logic [2:0] ADDR_HI_XRAM = 3'b101;

endpackage
`default_nettype wire

// File: rtl/gb_sync_vec.sv
`default_nettype none
// ============================================================================
// Module      : gb_sync_vec
// Description : Vector synchroniser, STAGES deep, with a per-bit reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_sync_vec #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gb_bus_capture.sv
`default_nettype none
// ============================================================================
// Module      : gb_bus_capture
// Description : Synchronises the cartridge bus and emits qualified, decoded
//               single-cycle write events. Optional statistics counters are
//               enabled with GB_BUS_CAPTURE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_bus_capture
    import gb_mbc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW_CYC = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        gb_addr_hi,
    input  logic [DATA_W-1:0] gb_data,
    input  logic              gb_write_n,
    input  logic              gb_read_n,
    input  logic              gb_cs_n,
    output logic              wr_valid,
    output logic [1:0]        wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              ram_wr_valid,
    output logic              wr_err,
`ifdef GB_BUS_CAPTURE_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_glitch_cnt,
`endif
    output logic              bus_idle
);

    localparam int c_BUS_W = DATA_W + 6;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_MIN_LOW = c_CNT_W'(MIN_LOW_CYC);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);
    localparam logic [c_BUS_W-1:0] c_SYNC_RST = {3'b000, {DATA_W{1'b0}}, 3'b111};

    logic [c_BUS_W-1:0]     w_sync;
    logic [2:0]             w_addr_s;
    logic [DATA_W-1:0]      w_data_s;
    logic                   w_wn_s;
    logic                   w_rn_s;
    logic                   w_csn_s;

    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   w_sync_vld;
    logic                   r_wn_prev;
    logic                   w_wn_fall;

    gb_cap_state_t          r_state;
    gb_cap_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_glitch;

    logic [2:0]             r_cap_addr;
    logic [DATA_W-1:0]      r_cap_data;
    logic                   r_cap_cs_n;

    logic                   r_wr_valid;
    logic                   r_ram_wr_valid;
    logic                   r_wr_err;
    logic [1:0]             r_wr_reg;
    logic [DATA_W-1:0]      r_wr_data;

    logic                   w_done_entry;
    logic                   w_is_mbc;
    logic                   w_is_xram;

    gb_sync_vec #(
        .WIDTH   (c_BUS_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (c_SYNC_RST)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({gb_addr_hi, gb_data, gb_write_n, gb_read_n, gb_cs_n}),
        .o_q (w_sync)
    );

    assign {w_addr_s, w_data_s, w_wn_s, w_rn_s, w_csn_s} = w_sync;

    // Edges are only trusted once the chain holds real samples, so a write
    // already low at reset release must first be seen high.
    assign w_sync_vld = r_sync_vld[SYNC_STAGES-1];
    assign w_wn_fall  = r_wn_prev & ~w_wn_s;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_glitch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_wn_fall) begin
                    w_state_nxt = ST_WR_LOW;
                    w_cnt_nxt   = c_CNT_W'(1);
                end
            end
            ST_WR_LOW: begin
                if (!w_rn_s) begin
                    w_state_nxt = ST_ABORT;
                end else if (w_wn_s) begin
                    if (r_cnt >= c_MIN_LOW) begin
                        w_state_nxt = ST_WR_DONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_glitch    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + c_CNT_W'(1);
                    if (w_cnt_nxt == c_TIMEOUT) begin
                        w_state_nxt = ST_ABORT;
                    end
                end
            end
            ST_WR_DONE: begin
                w_state_nxt = ST_IDLE;
                if (w_wn_fall) begin
                    w_state_nxt = ST_WR_LOW;
                    w_cnt_nxt   = c_CNT_W'(1);
                end
            end
            ST_ABORT: begin
                if (w_wn_s && w_rn_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_done_entry = (w_state_nxt == ST_WR_DONE);
    assign w_is_mbc     = ~r_cap_addr[2];
    assign w_is_xram    = (r_cap_addr == ADDR_HI_XRAM) & ~r_cap_cs_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_sync_vld     <= '0;
            r_wn_prev      <= 1'b0;
            r_cap_addr     <= '0;
            r_cap_data     <= '0;
            r_cap_cs_n     <= 1'b1;
            r_wr_valid     <= 1'b0;
            r_ram_wr_valid <= 1'b0;
            r_wr_err       <= 1'b0;
            r_wr_reg       <= '0;
            r_wr_data      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sync_vld     <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_wn_prev      <= w_sync_vld & w_wn_s;
            // Re-latch on every low cycle so the capture reflects the last one
            if (w_state_nxt == ST_WR_LOW) begin
                r_cap_addr <= w_addr_s;
                r_cap_data <= w_data_s;
                r_cap_cs_n <= w_csn_s;
            end
            r_wr_valid     <= w_done_entry & w_is_mbc;
            r_ram_wr_valid <= w_done_entry & w_is_xram;
            r_wr_err       <= (w_state_nxt == ST_ABORT) && (r_state != ST_ABORT);
            if (w_done_entry) begin
                r_wr_reg  <= r_cap_addr[1:0];
                r_wr_data <= r_cap_data;
            end
        end
    end

    assign wr_valid     = r_wr_valid;
    assign ram_wr_valid = r_ram_wr_valid;
    assign wr_err       = r_wr_err;
    assign wr_reg       = r_wr_reg;
    assign wr_data      = r_wr_data;
    assign bus_idle     = (r_state == ST_IDLE) & w_wn_s & w_rn_s;

`ifdef GB_BUS_CAPTURE_STATS_EN
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_glitch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr     <= '0;
            r_stat_glitch <= '0;
        end else begin
            if ((r_wr_valid || r_ram_wr_valid) && (r_stat_wr != 16'hFFFF)) begin
                r_stat_wr <= r_stat_wr + 16'd1;
            end
            if ((w_glitch || r_wr_err) && (r_stat_glitch != 16'hFFFF)) begin
                r_stat_glitch <= r_stat_glitch + 16'd1;
            end
        end
    end

    assign stat_wr_cnt     = r_stat_wr;
    assign stat_glitch_cnt = r_stat_glitch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_bus_capture
// Description : Self-checking bench for gb_bus_capture against a transaction
//               level model of the write qualification rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_bus_capture;

    localparam int SYNC = 2;
    localparam int MINL = 4;
    localparam int TMO  = 255;
    localparam int DW   = 8;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RAM  = 2;
    localparam int K_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    gb_addr_hi = '0;
    logic [DW-1:0] gb_data = '0;
    logic          gb_write_n = 1'b1;
    logic          gb_read_n = 1'b1;
    logic          gb_cs_n = 1'b1;
    logic          wr_valid;
    logic [1:0]    wr_reg;
    logic [DW-1:0] wr_data;
    logic          ram_wr_valid;
    logic          wr_err;
    logic          bus_idle;
`ifdef GB_BUS_CAPTURE_STATS_EN
    logic [15:0]   stat_wr_cnt;
    logic [15:0]   stat_glitch_cnt;
`endif

    gb_bus_capture #(
        .SYNC_STAGES (SYNC),
        .MIN_LOW_CYC (MINL),
        .TIMEOUT_CYC (TMO),
        .DATA_W      (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gb_addr_hi      (gb_addr_hi),
        .gb_data         (gb_data),
        .gb_write_n      (gb_write_n),
        .gb_read_n       (gb_read_n),
        .gb_cs_n         (gb_cs_n),
        .wr_valid        (wr_valid),
        .wr_reg          (wr_reg),
        .wr_data         (wr_data),
        .ram_wr_valid    (ram_wr_valid),
        .wr_err          (wr_err),
`ifdef GB_BUS_CAPTURE_STATS_EN
        .stat_wr_cnt     (stat_wr_cnt),
        .stat_glitch_cnt (stat_glitch_cnt),
`endif
        .bus_idle        (bus_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int            cyc;
        int            kind;
        logic [1:0]    rg;
        logic [DW-1:0] d;
    } ev_t;

    typedef struct {
        logic [2:0]    a;
        logic [DW-1:0] d;
        logic          cs;
        int            len;
        int            rd;
    } wr_t;

    ev_t evq[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_wr_cnt = 0;
    int  exp_gl_cnt = 0;

    // Output pulse monitor; also checks the three pulses never coincide
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid)     evq.push_back('{cyc: cyc, kind: K_WR,  rg: wr_reg, d: wr_data});
            if (ram_wr_valid) evq.push_back('{cyc: cyc, kind: K_RAM, rg: wr_reg, d: wr_data});
            if (wr_err)       evq.push_back('{cyc: cyc, kind: K_ERR, rg: wr_reg, d: wr_data});
            if (wr_valid || ram_wr_valid || wr_err) begin
                n_checks++;
                if (int'(wr_valid) + int'(ram_wr_valid) + int'(wr_err) > 1) begin
                    n_fail++;
                    $display("FAIL exclusive: wr_valid=%0b ram_wr_valid=%0b wr_err=%0b at cycle %0d, expected at most one",
                             wr_valid, ram_wr_valid, wr_err, cyc);
                end
            end
        end
    end

    // Outcome of one bus write from its address, chip select, low time and
    // whether a read strobe overlapped the low phase.
    function automatic int exp_kind(input logic [2:0] a, input logic cs, input int len, input int rd);
        if (rd >= 1 && rd < len) return K_ERR;
        if (len >= TMO)          return K_ERR;
        if (len < MINL)          return K_NONE;
        if (!a[2])               return K_WR;
        if (a == 3'b101 && !cs)  return K_RAM;
        return K_NONE;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // write_n low for len cycles; data switches to d1 in the last low cycle;
    // read_n pulses low for one cycle at low-cycle index rd (0 = never)
    task automatic drive_write(input logic [2:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic cs, input int len, input int rd,
                               output int fall_cyc, output int rise_cyc);
        @(negedge clk);
        gb_addr_hi = a;
        gb_cs_n    = cs;
        gb_data    = (len == 1) ? d1 : d0;
        gb_write_n = 1'b0;
        fall_cyc   = cyc;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            gb_read_n = (i == rd) ? 1'b0 : 1'b1;
            if (i == len - 1) gb_data = d1;
        end
        @(negedge clk);
        gb_write_n = 1'b1;
        gb_read_n  = 1'b1;
        gb_cs_n    = 1'b1;
        rise_cyc   = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++; if (wr_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_valid: got %0b expected 0", wr_valid); end
        n_checks++; if (ram_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wr_valid: got %0b expected 0", ram_wr_valid); end
        n_checks++; if (wr_err !== 1'b0)       begin n_fail++; $display("FAIL reset_wr_err: got %0b expected 0", wr_err); end
        n_checks++; if (bus_idle !== 1'b1)     begin n_fail++; $display("FAIL reset_bus_idle: got %0b expected 1", bus_idle); end
        n_checks++; if (wr_reg !== 2'd0)       begin n_fail++; $display("FAIL reset_wr_reg: got %0d expected 0", wr_reg); end
        n_checks++; if (wr_data !== '0)        begin n_fail++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
        rst = 1'b0;
        idle(SYNC + 2);
    endtask

    task automatic test_writes();
        wr_t           tbl[$];
        logic [DW-1:0] hold_data = '0;
        int            ek, f, r;
        tbl.push_back('{a: 3'b000, d: 8'h0A, cs: 1'b1, len: 10,       rd: 0});
        tbl.push_back('{a: 3'b001, d: 8'h33, cs: 1'b1, len: 2,        rd: 0});
        tbl.push_back('{a: 3'b101, d: 8'h5C, cs: 1'b0, len: 6,        rd: 0});
        tbl.push_back('{a: 3'b101, d: 8'h5C, cs: 1'b1, len: 6,        rd: 0});
        tbl.push_back('{a: 3'b011, d: 8'h77, cs: 1'b1, len: 8,        rd: 4});
        tbl.push_back('{a: 3'b010, d: 8'h44, cs: 1'b1, len: MINL,     rd: 0});
        tbl.push_back('{a: 3'b011, d: 8'h45, cs: 1'b1, len: MINL - 1, rd: 0});
        tbl.push_back('{a: 3'b110, d: 8'h99, cs: 1'b0, len: 6,        rd: 0});
        tbl.push_back('{a: 3'b001, d: 8'hE1, cs: 1'b1, len: TMO - 1,  rd: 0});
        for (int i = 0; i < 24; i++) begin
            tbl.push_back('{a: 3'($urandom_range(0, 7)), d: 8'($urandom), cs: 1'($urandom),
                            len: int'($urandom_range(1, 10)),
                            rd: ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0});
        end
        foreach (tbl[i]) begin
            evq.delete();
            drive_write(tbl[i].a, ~tbl[i].d, tbl[i].d, tbl[i].cs, tbl[i].len, tbl[i].rd, f, r);
            idle(SYNC + 6);
            ek = exp_kind(tbl[i].a, tbl[i].cs, tbl[i].len, tbl[i].rd);
            if (ek == K_WR || ek == K_RAM) exp_wr_cnt++;
            if (ek == K_ERR || (tbl[i].len < MINL && !(tbl[i].rd >= 1 && tbl[i].rd < tbl[i].len))) exp_gl_cnt++;
            if (exp_kind(tbl[i].a, 1'b0, tbl[i].len, tbl[i].rd) != K_ERR && tbl[i].len >= MINL) hold_data = tbl[i].d;
            n_checks++;
            if (ek == K_NONE) begin
                if (evq.size() != 0) begin
                    n_fail++;
                    $display("FAIL no_pulse[%0d]: got %0d pulses (first kind %0d) expected 0", i, evq.size(), evq[0].kind);
                end
            end else if (evq.size() != 1 || evq[0].kind != ek) begin
                n_fail++;
                $display("FAIL pulse_kind[%0d]: got %0d pulses (first kind %0d) expected one of kind %0d",
                         i, evq.size(), (evq.size() > 0) ? evq[0].kind : -1, ek);
            end else if (ek != K_ERR) begin
                n_checks++;
                if (evq[0].cyc != r + SYNC + 1) begin
                    n_fail++;
                    $display("FAIL latency[%0d]: got cycle %0d expected %0d", i, evq[0].cyc, r + SYNC + 1);
                end
                n_checks++;
                if (evq[0].d !== tbl[i].d) begin
                    n_fail++;
                    $display("FAIL pulse_data[%0d]: got %0h expected %0h", i, evq[0].d, tbl[i].d);
                end
                if (ek == K_WR) begin
                    n_checks++;
                    if (evq[0].rg !== tbl[i].a[1:0]) begin
                        n_fail++;
                        $display("FAIL wr_reg[%0d]: got %0d expected %0d", i, evq[0].rg, tbl[i].a[1:0]);
                    end
                end
            end
            n_checks++;
            if (wr_data !== hold_data) begin
                n_fail++;
                $display("FAIL data_hold[%0d]: got %0h expected %0h", i, wr_data, hold_data);
            end
            n_checks++;
            if (bus_idle !== 1'b1) begin
                n_fail++;
                $display("FAIL bus_idle_after[%0d]: got %0b expected 1", i, bus_idle);
            end
        end
`ifdef GB_BUS_CAPTURE_STATS_EN
        n_checks++;
        if (stat_wr_cnt !== 16'(exp_wr_cnt)) begin
            n_fail++; $display("FAIL stat_wr_cnt: got %0d expected %0d", stat_wr_cnt, exp_wr_cnt);
        end
        n_checks++;
        if (stat_glitch_cnt !== 16'(exp_gl_cnt)) begin
            n_fail++; $display("FAIL stat_glitch_cnt: got %0d expected %0d", stat_glitch_cnt, exp_gl_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int f1, r1, f2, r2;
        evq.delete();
        drive_write(3'b000, 8'h00, 8'hA1, 1'b1, 5, 0, f1, r1);
        drive_write(3'b010, 8'h00, 8'hB2, 1'b1, 5, 0, f2, r2);
        idle(SYNC + 6);
        n_checks++;
        if (evq.size() != 2 || evq[0].kind != K_WR || evq[1].kind != K_WR) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses expected 2 wr_valid", evq.size());
        end else begin
            n_checks++;
            if (evq[0].cyc != r1 + SYNC + 1 || evq[0].d !== 8'hA1 || evq[0].rg !== 2'd0) begin
                n_fail++;
                $display("FAIL b2b_first: got cyc %0d data %0h reg %0d expected cyc %0d data a1 reg 0",
                         evq[0].cyc, evq[0].d, evq[0].rg, r1 + SYNC + 1);
            end
            n_checks++;
            if (evq[1].cyc != r2 + SYNC + 1 || evq[1].d !== 8'hB2 || evq[1].rg !== 2'd2) begin
                n_fail++;
                $display("FAIL b2b_second: got cyc %0d data %0h reg %0d expected cyc %0d data b2 reg 2",
                         evq[1].cyc, evq[1].d, evq[1].rg, r2 + SYNC + 1);
            end
        end
    endtask

    task automatic test_timeout();
        int f;
        evq.delete();
        @(negedge clk);
        gb_addr_hi = 3'b000;
        gb_data    = 8'h12;
        gb_write_n = 1'b0;
        f = cyc;
        idle(299);
        n_checks++;
        if (bus_idle !== 1'b0) begin
            n_fail++; $display("FAIL timeout_busy: got bus_idle %0b expected 0", bus_idle);
        end
        n_checks++;
        if (evq.size() != 1 || evq[0].kind != K_ERR) begin
            n_fail++; $display("FAIL timeout_err: got %0d pulses expected exactly one wr_err", evq.size());
        end else begin
            n_checks++;
            if (evq[0].cyc != f + SYNC + TMO) begin
                n_fail++; $display("FAIL timeout_when: got cycle %0d expected %0d", evq[0].cyc, f + SYNC + TMO);
            end
        end
        gb_write_n = 1'b1;
        idle(SYNC + 4);
        n_checks++;
        if (bus_idle !== 1'b1) begin
            n_fail++; $display("FAIL timeout_recover: got bus_idle %0b expected 1", bus_idle);
        end
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL timeout_no_write: got %0d pulses expected 1", evq.size());
        end
    endtask

    task automatic test_rst_mid_write();
        int f, r;
        evq.delete();
        @(negedge clk);
        gb_addr_hi = 3'b000;
        gb_data    = 8'h33;
        gb_write_n = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(4);
        gb_write_n = 1'b1;
        idle(SYNC + 6);
        n_checks++;
        if (evq.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_write: got %0d pulses expected 0", evq.size());
        end
        n_checks++;
        if (bus_idle !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_idle: got bus_idle %0b expected 1", bus_idle);
        end
        drive_write(3'b001, 8'h00, 8'h1F, 1'b1, 6, 0, f, r);
        idle(SYNC + 6);
        n_checks++;
        if (evq.size() != 1 || evq[0].kind != K_WR || evq[0].rg !== 2'd1 || evq[0].d !== 8'h1F) begin
            n_fail++;
            $display("FAIL after_rst_write: got %0d pulses (reg %0d data %0h) expected one wr_valid reg 1 data 1f",
                     evq.size(), (evq.size() > 0) ? evq[0].rg : 2'd0, (evq.size() > 0) ? evq[0].d : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_back_to_back();
        test_timeout();
        test_rst_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
